// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction-fetch stage: PC, ROM address, IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter int          ROM_BYTES = 4096,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  // Highest word address that still lies inside the ROM.
  localparam logic [31:0] LAST_PC = RESET_PC + 32'(ROM_BYTES - 4);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        bad;
  logic        if_load;

  // Fault detection and the "IF/ID takes a fresh fetch" qualifier.
  always_comb begin
    pc_plus4 = pc + 32'd4;
    bad      = (pc[1:0] != 2'b00) || (pc < RESET_PC) || (pc > LAST_PC);
    if_load  = !redirect && !flush && !stall;
  end

  assign imem_addr = pc;
  assign pc_f      = pc;

  // Program counter: a redirect beats a stall so a resolved branch is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (!stall) begin
      pc <= pc_plus4;
    end
  end

  // IF/ID register: bubbles on redirect/flush, holds on stall, bubbles on a bad fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= 32'd0;
      pc_plus4_d <= 32'd0;
      valid_d    <= 1'b0;
    end else if (redirect || flush) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (!stall) begin
      pc_d       <= pc;
      pc_plus4_d <= pc_plus4;
      if (bad) begin
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end else begin
        instr_d <= imem_dout;
        valid_d <= 1'b1;
      end
    end
  end

  // Sticky fault flag and count of real instructions handed to decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_fault <= 1'b0;
      fetch_count <= 32'd0;
    end else if (if_load) begin
      if (bad) begin
        fetch_fault <= 1'b1;
      end else begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_dout, pc_f, instr_d, pc_d, pc_plus4_d, fetch_count;
  logic        valid_d, fetch_fault;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input int idx);
    return {16'hC0DE, 16'(idx)} ^ 32'h00A50000;
  endfunction

  function automatic bit in_rom(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && (a <= BASE + 32'd4092);
  endfunction

  function automatic logic [31:0] rom_at(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return rom_word(int'(off[11:2]));
  endfunction

  // Instruction ROM; garbage outside the window so ignored data is visible.
  always_comb begin
    imem_dout = 32'hDEADBEEF;
    if (in_rom(imem_addr)) imem_dout = rom_at(imem_addr);
  end

  // Behavioural model of the stage state.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4;
  logic        m_valid, m_fault;
  logic [31:0] m_count;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = BASE; m_instr = NOP; m_pcd = 0; m_pc4 = 0;
      m_valid = 0; m_fault = 0; m_count = 0;
    end else begin
      if (redirect || flush) begin
        m_instr = NOP; m_valid = 0;
      end else if (!stall) begin
        m_pcd = m_pc;
        m_pc4 = m_pc + 4;
        if (in_rom(m_pc)) begin
          m_instr = rom_at(m_pc); m_valid = 1; m_count = m_count + 1;
        end else begin
          m_instr = NOP; m_valid = 0; m_fault = 1;
        end
      end
      if (redirect)    m_pc = redirect_pc;
      else if (!stall) m_pc = m_pc + 4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.pc_f", pc_f, m_pc);
      chk("m.imem_addr", imem_addr, m_pc);
      chk("m.instr_d", instr_d, m_instr);
      chk("m.pc_d", pc_d, m_pcd);
      chk("m.pc_plus4_d", pc_plus4_d, m_pc4);
      chk("m.valid_d", 32'(valid_d), 32'(m_valid));
      chk("m.fetch_fault", 32'(fetch_fault), 32'(m_fault));
      chk("m.fetch_count", fetch_count, m_count);
    end
  end

  task automatic cyc(input logic r, input logic s, input logic f, input logic rd,
                     input logic [31:0] rpc);
    rst = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; redirect = 0; redirect_pc = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst.pc", pc_f, BASE);
    chk("rst.instr", instr_d, NOP);
    chk("rst.valid", 32'(valid_d), 0);
    chk("rst.count", fetch_count, 0);
    chk("rst.pc_d", pc_d, 0);

    // Free run.
    cyc(0, 0, 0, 0, 0);
    chk("run.addr1", imem_addr, 32'hBFC00004);
    chk("run.instr", instr_d, rom_word(0));
    chk("run.pc_d", pc_d, 32'hBFC00000);
    chk("run.pc4", pc_plus4_d, 32'hBFC00004);
    cyc(0, 0, 0, 0, 0);
    chk("run.addr2", imem_addr, 32'hBFC00008);
    cyc(0, 0, 0, 0, 0);
    chk("run.addr3", imem_addr, 32'hBFC0000C);
    chk("run.count", fetch_count, 3);

    // Stall at BFC00008.
    cyc(0, 0, 0, 1, 32'hBFC00008);
    chk("stl.pc0", pc_f, 32'hBFC00008);
    cyc(0, 1, 0, 0, 0);
    chk("stl.pc1", pc_f, 32'hBFC00008);
    chk("stl.cnt1", fetch_count, 3);
    cyc(0, 1, 0, 0, 0);
    chk("stl.pc2", pc_f, 32'hBFC00008);
    chk("stl.cnt2", fetch_count, 3);
    cyc(0, 0, 0, 0, 0);
    chk("stl.resume_pc", pc_f, 32'hBFC0000C);
    chk("stl.resume_instr", instr_d, rom_word(2));
    chk("stl.resume_cnt", fetch_count, 4);

    // Flush at BFC00010.
    cyc(0, 0, 0, 0, 0);
    chk("fl.pc_before", pc_f, 32'hBFC00010);
    cyc(0, 0, 1, 0, 0);
    chk("fl.instr", instr_d, NOP);
    chk("fl.valid", 32'(valid_d), 0);
    chk("fl.pc", pc_f, 32'hBFC00014);
    chk("fl.count", fetch_count, 5);

    // Redirect together with stall.
    cyc(0, 1, 0, 1, 32'hBFC00100);
    chk("rs.pc", pc_f, 32'hBFC00100);
    chk("rs.instr", instr_d, NOP);
    chk("rs.valid", 32'(valid_d), 0);
    cyc(0, 0, 0, 0, 0);
    chk("rs.instr2", instr_d, rom_word(64));
    chk("rs.pc_d2", pc_d, 32'hBFC00100);

    // Misaligned redirect.
    cyc(0, 0, 0, 1, 32'hBFC00102);
    chk("mis.pc", pc_f, 32'hBFC00102);
    chk("mis.fault0", 32'(fetch_fault), 0);
    cyc(0, 0, 0, 0, 0);
    chk("mis.valid", 32'(valid_d), 0);
    chk("mis.fault1", 32'(fetch_fault), 1);
    chk("mis.pc_d", pc_d, 32'hBFC00102);
    cyc(0, 0, 0, 1, BASE);
    cyc(0, 0, 0, 0, 0);
    chk("mis.recover_instr", instr_d, rom_word(0));
    chk("mis.recover_valid", 32'(valid_d), 1);
    chk("mis.sticky", 32'(fetch_fault), 1);
    chk("mis.count", fetch_count, 7);

    // Flush with stall: PC holds, bubble inserted.
    cyc(0, 1, 1, 0, 0);
    chk("fs.pc", pc_f, 32'hBFC00004);
    chk("fs.valid", 32'(valid_d), 0);

    // Reset mid-run against redirect and stall.
    cyc(1, 1, 0, 1, 32'hBFC00200);
    chk("mr.pc", pc_f, BASE);
    chk("mr.valid", 32'(valid_d), 0);
    chk("mr.fault", 32'(fetch_fault), 0);
    chk("mr.count", fetch_count, 0);

    // Run off the end of the ROM.
    cyc(0, 0, 0, 1, 32'hBFC00FF8);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("end.pc", pc_f, 32'hBFC01000);
    chk("end.instr", instr_d, rom_word(1023));
    chk("end.fault0", 32'(fetch_fault), 0);
    chk("end.count", fetch_count, 2);
    cyc(0, 0, 0, 0, 0);
    chk("end.fault1", 32'(fetch_fault), 1);
    chk("end.valid", 32'(valid_d), 0);
    chk("end.pc_d", pc_d, 32'hBFC01000);

    // PC wraps modulo 2^32.
    cyc(0, 0, 0, 1, 32'hFFFFFFFC);
    cyc(0, 0, 0, 0, 0);
    chk("wrap.pc", pc_f, 32'h00000000);
    chk("wrap.pc4", pc_plus4_d, 32'h00000000);
    cyc(0, 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
